// File: rtl/seq_control_ws_if.sv
// rtl/seq_control_ws_if.sv - sequence controller bus: IR/flag inputs and datapath strobes
interface seq_control_ws_if #(
   parameter int DataWidth = 16,
   parameter int CntWidth  = 16
);
   logic [DataWidth-1:0] IR;
   logic [3:0]           ALU_FlgsIn;
   logic                 Resume;
   logic                 STK_Ld, BRA_Src, IR_Ld, PC_Ld, PC_Rst, PC_Inc;
   logic [1:0]           PC_Src, ADDR_Src, DATA_Src;
   logic                 MEM_Wr, MEM_En, REG_WE;
   logic [2:0]           REG_Dest, REG_Src2, REG_Src1;
   logic                 Src1_Sel;
   logic [3:0]           ALU_Op;
   logic                 ALU_Ld, FLG_Ld, FLG_Rst;
   logic                 Halt, Illegal;
   logic [CntWidth-1:0]  InstrCnt;

   modport master (
      input  IR, ALU_FlgsIn, Resume,
      output STK_Ld, BRA_Src, IR_Ld, PC_Ld, PC_Rst, PC_Inc,
             PC_Src, ADDR_Src, DATA_Src, MEM_Wr, MEM_En, REG_WE,
             REG_Dest, REG_Src2, REG_Src1, Src1_Sel, ALU_Op,
             ALU_Ld, FLG_Ld, FLG_Rst, Halt, Illegal, InstrCnt
   );

   modport slave (
      output IR, ALU_FlgsIn, Resume,
      input  STK_Ld, BRA_Src, IR_Ld, PC_Ld, PC_Rst, PC_Inc,
             PC_Src, ADDR_Src, DATA_Src, MEM_Wr, MEM_En, REG_WE,
             REG_Dest, REG_Src2, REG_Src1, Src1_Sel, ALU_Op,
             ALU_Ld, FLG_Ld, FLG_Rst, Halt, Illegal, InstrCnt
   );
endinterface

// File: rtl/seq_control_ws.sv
// rtl/seq_control_ws.sv - fetch/decode/execute sequencer with memory wait states and halt
module seq_control_ws #(
   parameter int DataWidth  = 16,
   parameter int WaitStates = 0,
   parameter int CntWidth   = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   seq_control_ws_if.master  bus
);
   typedef enum logic [2:0] {
      S_Reset  = 3'd0,
      S_Fetch  = 3'd1,
      S_Load   = 3'd2,
      S_Decode = 3'd3,
      S_Exec   = 3'd4,
      S_Halt   = 3'd5
   } state_t;

   localparam logic [3:0] WS = 4'(WaitStates);

   state_t              state_q, state_d;
   logic [3:0]          wait_q, wait_d;
   logic [3:0]          alu_op_q, alu_op_d;
   logic [CntWidth-1:0] cnt_q, cnt_d;

   logic [3:0] opcode;
   logic       wait_tc, is_mem, is_alu, exec_done, taken, mem_phase;
   logic       unused_ir;

   assign opcode    = bus.IR[DataWidth-1 -: 4];
   assign wait_tc   = (wait_q == WS);
   assign is_mem    = (opcode == 4'h3) || (opcode == 4'h4) || (opcode == 4'h5);
   assign is_alu    = (opcode >= 4'hA) && (opcode <= 4'hE);
   assign exec_done = !is_mem || wait_tc;
   assign unused_ir = ^bus.IR;

   // Flags are {V,N,C,Z}
   always_comb begin
      taken = 1'b0;
      case (bus.IR[11:10])
         2'b00:   taken = bus.ALU_FlgsIn[0];
         2'b01:   taken = !bus.ALU_FlgsIn[0];
         2'b10:   taken = bus.ALU_FlgsIn[2] ^ bus.ALU_FlgsIn[3];
         default: taken = bus.ALU_FlgsIn[1];
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q  <= S_Reset;
         wait_q   <= 4'd0;
         alu_op_q <= 4'd0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         alu_op_q <= alu_op_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      wait_d   = 4'd0;
      alu_op_d = alu_op_q;
      cnt_d    = cnt_q;
      case (state_q)
         S_Reset: state_d = S_Fetch;
         S_Fetch: begin
            if (wait_tc) state_d = S_Load;
            else         wait_d  = wait_q + 4'd1;
         end
         S_Load: state_d = S_Decode;
         S_Decode: begin
            cnt_d   = cnt_q + CntWidth'(1);
            state_d = S_Fetch;
            case (opcode)
               4'h1: state_d = S_Halt;
               4'h3: state_d = S_Exec;
               4'h4, 4'h5: if (WS != 4'd0) state_d = S_Exec;
               4'hA, 4'hB, 4'hC, 4'hD, 4'hE: begin
                  state_d  = S_Exec;
                  alu_op_d = opcode - 4'hA;
               end
               default: ;
            endcase
         end
         S_Exec: begin
            if (exec_done) state_d = S_Fetch;
            else           wait_d  = wait_q + 4'd1;
         end
         S_Halt: if (bus.Resume) state_d = S_Fetch;
         default: state_d = S_Reset;
      endcase
   end

   always_comb begin
      bus.STK_Ld   = 1'b1;
      bus.BRA_Src  = 1'b1;
      bus.IR_Ld    = 1'b1;
      bus.PC_Ld    = 1'b1;
      bus.PC_Rst   = 1'b1;
      bus.PC_Inc   = 1'b1;
      bus.PC_Src   = 2'b00;
      bus.ADDR_Src = 2'b00;
      bus.DATA_Src = 2'b00;
      bus.MEM_Wr   = 1'b1;
      bus.MEM_En   = 1'b1;
      bus.REG_WE   = 1'b1;
      bus.Src1_Sel = 1'b1;
      bus.ALU_Ld   = 1'b1;
      bus.FLG_Ld   = 1'b1;
      bus.FLG_Rst  = 1'b1;
      bus.Halt     = 1'b0;
      bus.Illegal  = 1'b0;
      mem_phase    = (state_q == S_Decode) || (state_q == S_Exec && !exec_done);
      case (state_q)
         S_Reset: bus.PC_Rst = 1'b0;
         S_Fetch: bus.MEM_En = 1'b0;
         S_Load: begin
            bus.IR_Ld  = 1'b0;
            bus.PC_Inc = 1'b0;
         end
         S_Decode: begin
            case (opcode)
               4'h2: bus.REG_WE = 1'b0;
               4'h6: begin
                  bus.PC_Src = 2'b10;
                  bus.PC_Ld  = 1'b0;
                  bus.STK_Ld = bus.IR[11];
               end
               4'h7: begin
                  bus.PC_Src = 2'b01;
                  bus.PC_Ld  = 1'b0;
               end
               4'h8, 4'h9: begin
                  bus.FLG_Rst = 1'b0;
                  if (taken) begin
                     bus.PC_Ld   = 1'b0;
                     bus.BRA_Src = (opcode == 4'h8);
                  end
               end
               4'hA, 4'hB, 4'hC, 4'hD, 4'hE: begin
                  bus.FLG_Ld = 1'b0;
                  bus.ALU_Ld = 1'b0;
               end
               4'hF: bus.Illegal = 1'b0 | 1'b1;
               default: ;
            endcase
         end
         S_Exec: begin
            if (exec_done && opcode == 4'h3) begin
               bus.REG_WE   = 1'b0;
               bus.DATA_Src = 2'b01;
            end else if (is_alu) begin
               bus.REG_WE   = 1'b0;
               bus.DATA_Src = 2'b10;
            end
         end
         S_Halt: bus.Halt = 1'b1;
         default: ;
      endcase
      // Memory strobes stay asserted from Decode until the wait count expires
      if (mem_phase) begin
         case (opcode)
            4'h3: begin
               bus.MEM_En   = 1'b0;
               bus.ADDR_Src = 2'b10;
            end
            4'h4: begin
               bus.MEM_Wr   = 1'b0;
               bus.MEM_En   = 1'b0;
               bus.ADDR_Src = 2'b10;
               bus.Src1_Sel = 1'b0;
            end
            4'h5: begin
               bus.MEM_Wr   = 1'b0;
               bus.MEM_En   = 1'b0;
               bus.ADDR_Src = 2'b01;
            end
            default: ;
         endcase
      end
   end

   assign bus.REG_Dest = bus.IR[11:9];
   assign bus.REG_Src2 = bus.IR[6:4];
   assign bus.REG_Src1 = bus.IR[2:0];
   assign bus.ALU_Op   = alu_op_q;
   assign bus.InstrCnt = cnt_q;
endmodule

// File: tb/tb_seq_control_ws.sv
// tb/tb_seq_control_ws.sv - directed bench for seq_control_ws at 0, 2 and 3 wait states
module tb_seq_control_ws;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] ir = 16'h0000;
   logic [3:0]  flg = 4'b0000;
   logic        resume = 1'b0;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   seq_control_ws_if #(.DataWidth(16), .CntWidth(3))  if0 ();
   seq_control_ws_if #(.DataWidth(16), .CntWidth(16)) if2 ();
   seq_control_ws_if #(.DataWidth(16), .CntWidth(16)) if3 ();

   assign if0.IR = ir;  assign if0.ALU_FlgsIn = flg;  assign if0.Resume = resume;
   assign if2.IR = ir;  assign if2.ALU_FlgsIn = flg;  assign if2.Resume = resume;
   assign if3.IR = ir;  assign if3.ALU_FlgsIn = flg;  assign if3.Resume = resume;

   seq_control_ws #(.DataWidth(16), .WaitStates(0), .CntWidth(3))  u0 (.Clk(clk), .Reset(rst_n), .bus(if0.master));
   seq_control_ws #(.DataWidth(16), .WaitStates(2), .CntWidth(16)) u2 (.Clk(clk), .Reset(rst_n), .bus(if2.master));
   seq_control_ws #(.DataWidth(16), .WaitStates(3), .CntWidth(16)) u3 (.Clk(clk), .Reset(rst_n), .bus(if3.master));

   task automatic step;
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      step(); step(); step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      ir = 16'h0000; flg = 4'b0000; resume = 1'b0;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({if0.PC_Rst, if0.MEM_En, if0.IR_Ld, if0.InstrCnt, if0.ALU_Op, if0.Halt} !== {1'b0, 1'b1, 1'b1, 3'd0, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got=%0h exp=%0h", {if0.PC_Rst, if0.MEM_En, if0.IR_Ld, if0.InstrCnt, if0.ALU_Op, if0.Halt}, {1'b0, 1'b1, 1'b1, 3'd0, 4'd0, 1'b0});
         end
      end
      rst_n = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step();
         checks++;
         if ({if0.MEM_En, if0.IR_Ld, if0.PC_Rst} !== 3'b011) begin
            failures++;
            $display("FAIL nop_fetch%0d got=%b exp=011", k, {if0.MEM_En, if0.IR_Ld, if0.PC_Rst});
         end
         step();
         checks++;
         if ({if0.MEM_En, if0.IR_Ld, if0.PC_Inc} !== 3'b100) begin
            failures++;
            $display("FAIL nop_load%0d got=%b exp=100", k, {if0.MEM_En, if0.IR_Ld, if0.PC_Inc});
         end
         step();
         checks++;
         if ({if0.MEM_En, if0.IR_Ld, if0.InstrCnt} !== {1'b1, 1'b1, 3'(k - 1)}) begin
            failures++;
            $display("FAIL nop_decode%0d got=%0h exp=%0h", k, {if0.MEM_En, if0.IR_Ld, if0.InstrCnt}, {1'b1, 1'b1, 3'(k - 1)});
         end
      end
      step();
      checks++;
      if (if0.InstrCnt !== 3'd3) begin
         failures++;
         $display("FAIL nop_count got=%0d exp=3", if0.InstrCnt);
      end
   endtask

   task automatic test_ld_wait;
      logic [8:0] mem_en_tbl;
      logic [5:0] exp;
      mem_en_tbl = 9'b010001000;
      ir = 16'h3005;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         step();
         exp = {mem_en_tbl[i], (i == 7) ? 1'b0 : 1'b1, (i == 7) ? 2'b01 : 2'b00, (i >= 4 && i <= 6) ? 2'b10 : 2'b00};
         checks++;
         if ({if2.MEM_En, if2.REG_WE, if2.DATA_Src, if2.ADDR_Src} !== exp) begin
            failures++;
            $display("FAIL ld_w2_cycle%0d got=%b exp=%b", i, {if2.MEM_En, if2.REG_WE, if2.DATA_Src, if2.ADDR_Src}, exp);
         end
      end
   endtask

   task automatic test_branch;
      ir = 16'h8000; flg = 4'b0001;
      do_reset();
      step(); step(); step();
      checks++;
      if ({if0.PC_Ld, if0.BRA_Src, if0.FLG_Rst, if0.PC_Src} !== 5'b01000) begin
         failures++;
         $display("FAIL beq_taken got=%b exp=01000", {if0.PC_Ld, if0.BRA_Src, if0.FLG_Rst, if0.PC_Src});
      end
      flg = 4'b0000;
      step(); step(); step();
      checks++;
      if ({if0.PC_Ld, if0.FLG_Rst} !== 2'b10) begin
         failures++;
         $display("FAIL beq_not_taken got=%b exp=10", {if0.PC_Ld, if0.FLG_Rst});
      end
      ir = 16'h9800; flg = 4'b0100;
      step(); step(); step();
      checks++;
      if ({if0.PC_Ld, if0.BRA_Src, if0.FLG_Rst} !== 3'b000) begin
         failures++;
         $display("FAIL brx_nv_taken got=%b exp=000", {if0.PC_Ld, if0.BRA_Src, if0.FLG_Rst});
      end
      flg = 4'b0000;
   endtask

   task automatic test_alu;
      ir = 16'hA215;
      do_reset();
      step(); step(); step();
      checks++;
      if ({if0.ALU_Ld, if0.FLG_Ld, if0.ALU_Op, if0.REG_WE} !== 7'b0000001) begin
         failures++;
         $display("FAIL add_decode got=%b exp=0000001", {if0.ALU_Ld, if0.FLG_Ld, if0.ALU_Op, if0.REG_WE});
      end
      step();
      checks++;
      if ({if0.REG_WE, if0.DATA_Src, if0.REG_Dest, if0.REG_Src2, if0.REG_Src1, if0.ALU_Op} !== {1'b0, 2'b10, 3'd1, 3'd1, 3'd5, 4'd0}) begin
         failures++;
         $display("FAIL add_exec got=%0h exp=%0h", {if0.REG_WE, if0.DATA_Src, if0.REG_Dest, if0.REG_Src2, if0.REG_Src1, if0.ALU_Op}, {1'b0, 2'b10, 3'd1, 3'd1, 3'd5, 4'd0});
      end
      ir = 16'hB000;
      step(); step(); step(); step();
      checks++;
      if ({if0.REG_WE, if0.DATA_Src, if0.ALU_Op} !== 7'b0100001) begin
         failures++;
         $display("FAIL sub_exec got=%b exp=0100001", {if0.REG_WE, if0.DATA_Src, if0.ALU_Op});
      end
      ir = 16'hE000;
      step(); step(); step(); step();
      checks++;
      if (if0.ALU_Op !== 4'b0100) begin
         failures++;
         $display("FAIL xor_exec got=%b exp=0100", if0.ALU_Op);
      end
   endtask

   task automatic test_halt;
      ir = 16'h1000;
      do_reset();
      resume = 1'b1;
      step();
      step();
      checks++;
      if ({if0.IR_Ld, if0.Halt} !== 2'b00) begin
         failures++;
         $display("FAIL resume_ignored got=%b exp=00", {if0.IR_Ld, if0.Halt});
      end
      resume = 1'b0;
      step();
      step();
      for (int i = 0; i < 10; i++) begin
         checks++;
         if ({if0.Halt, if0.InstrCnt} !== {1'b1, 3'd1}) begin
            failures++;
            $display("FAIL halt_hold%0d got=%0h exp=%0h", i, {if0.Halt, if0.InstrCnt}, {1'b1, 3'd1});
         end
         step();
      end
      resume = 1'b1;
      ir = 16'h0000;
      step();
      resume = 1'b0;
      checks++;
      if ({if0.Halt, if0.MEM_En, if0.InstrCnt} !== {1'b0, 1'b0, 3'd1}) begin
         failures++;
         $display("FAIL halt_resume got=%0h exp=%0h", {if0.Halt, if0.MEM_En, if0.InstrCnt}, {1'b0, 1'b0, 3'd1});
      end
   endtask

   task automatic test_illegal;
      ir = 16'hF000;
      do_reset();
      step(); step(); step();
      checks++;
      if (if0.Illegal !== 1'b1) begin
         failures++;
         $display("FAIL illegal_pulse got=%b exp=1", if0.Illegal);
      end
      step();
      checks++;
      if ({if0.Illegal, if0.InstrCnt} !== {1'b0, 3'd1}) begin
         failures++;
         $display("FAIL illegal_clear got=%0h exp=%0h", {if0.Illegal, if0.InstrCnt}, {1'b0, 3'd1});
      end
   endtask

   task automatic test_store;
      ir = 16'h4000;
      do_reset();
      step(); step(); step();
      checks++;
      if ({if0.MEM_Wr, if0.MEM_En, if0.ADDR_Src, if0.Src1_Sel} !== 5'b00100) begin
         failures++;
         $display("FAIL st_w0_decode got=%b exp=00100", {if0.MEM_Wr, if0.MEM_En, if0.ADDR_Src, if0.Src1_Sel});
      end
      ir = 16'h5000;
      step();
      checks++;
      if ({if0.MEM_Wr, if0.MEM_En, if0.ADDR_Src} !== 4'b1000) begin
         failures++;
         $display("FAIL st_w0_fetch got=%b exp=1000", {if0.MEM_Wr, if0.MEM_En, if0.ADDR_Src});
      end
      step(); step();
      checks++;
      if ({if0.MEM_Wr, if0.MEM_En, if0.ADDR_Src, if0.Src1_Sel} !== 5'b00011) begin
         failures++;
         $display("FAIL stx_w0_decode got=%b exp=00011", {if0.MEM_Wr, if0.MEM_En, if0.ADDR_Src, if0.Src1_Sel});
      end
   endtask

   task automatic test_reset_mid_store;
      ir = 16'h4000;
      do_reset();
      for (int i = 0; i < 7; i++) step();
      checks++;
      if ({if3.MEM_Wr, if3.MEM_En} !== 2'b00) begin
         failures++;
         $display("FAIL st_w3_exec got=%b exp=00", {if3.MEM_Wr, if3.MEM_En});
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({if3.MEM_Wr, if3.MEM_En, if3.PC_Rst} !== 3'b110) begin
         failures++;
         $display("FAIL st_w3_async_reset got=%b exp=110", {if3.MEM_Wr, if3.MEM_En, if3.PC_Rst});
      end
      step();
      rst_n = 1'b1;
      ir = 16'h0000;
   endtask

   task automatic test_back_to_back;
      ir = 16'h0000;
      do_reset();
      for (int k = 1; k <= 8; k++) begin
         step(); step(); step();
         checks++;
         if (if0.InstrCnt !== 3'(k - 1)) begin
            failures++;
            $display("FAIL cnt_decode%0d got=%0d exp=%0d", k, if0.InstrCnt, 3'(k - 1));
         end
      end
      step();
      checks++;
      if (if0.InstrCnt !== 3'd0) begin
         failures++;
         $display("FAIL cnt_wrap got=%0d exp=0", if0.InstrCnt);
      end
   endtask

   initial begin
      test_reset();
      test_ld_wait();
      test_branch();
      test_alu();
      test_halt();
      test_illegal();
      test_store();
      test_reset_mid_store();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/seq_control_ws.md
Name: seq_control_ws

Overview:
Parametrised successor of the A09 sequence controller. It is a multi-cycle fetch/decode/execute FSM that drives the active-low datapath strobes (PC, IR, memory, register file, ALU, flags). New over the previous generation:
- generic instruction width
- a configurable memory wait-state counter on every memory access
- a resumable halt state
- an illegal-opcode strobe
- a retired-instruction counter
It sits between the IR/flag registers and the A09 datapath muxes.

Parameters:
DataWidth, 16, instruction width; opcode = IR[DataWidth-1:DataWidth-4]; must be >= 16.
WaitStates, 0, extra cycles each memory access is held before completing (0..15).
CntWidth, 16, width of the retired-instruction counter.

Ports:
Clk  in  1  system clock, rising edge.
Reset  in  1  asynchronous, active-low; forces S_Reset immediately.
IR  in  DataWidth  current instruction. Fields: Dest IR[11:9], Src2 IR[6:4], Src1 IR[2:0], CN IR[11:10], Link IR[11].
ALU_FlgsIn  in  4  {V,N,C,Z}; Z is bit 0.
Resume  in  1  active-high; leaves S_Halt.
STK_Ld, BRA_Src, IR_Ld, PC_Ld, PC_Rst, PC_Inc  out  1 each  active-low strobes (BRA_Src: 1 = sign-extend, 0 = reg Src1).
PC_Src, ADDR_Src, DATA_Src  out  2 each  mux selects.
MEM_Wr (0 = write), MEM_En (0 = enable), REG_WE (0 = write)  out  1 each.
REG_Dest, REG_Src2, REG_Src1  out  3 each  IR field pass-through.
Src1_Sel  out  1  1 = IR[2:0], 0 = IR[11:9] to reg-file Src1.
ALU_Op  out  4  ALU operation.
ALU_Ld, FLG_Ld, FLG_Rst  out  1 each  active-low.
Halt  out  1  active-high, asserted in S_Halt.
Illegal  out  1  one-cycle pulse on decode of opcode 4'hF.
InstrCnt  out  CntWidth  retired-instruction count.

Behaviour:
- Single clock domain; all flops reset asynchronously on Reset=0.
- State, wait counter, ALU_Op register and InstrCnt are registered. Strobes decode combinationally from state + IR + flags.
- Default for every strobe in every state: inactive (active-low = 1, Halt=0, Illegal=0). ADDR_Src, PC_Src and DATA_Src default to 00; Src1_Sel defaults to 1.
- Reset values: state=S_Reset, PC_Rst=0, wait counter=0, ALU_Op=0, InstrCnt=0, all other strobes at default.
- S_Reset -> S_Fetch on the first clock with Reset=1.
- S_Fetch: MEM_En=0, MEM_Wr=1, ADDR_Src=00. Wait counter counts 0..WaitStates; at terminal count -> S_Load and the counter clears.
- S_Load: IR_Ld=0, PC_Inc=0; -> S_Decode.
- S_Decode: InstrCnt increments (wraps at 2^CntWidth-1 -> 0). Default next state is S_Fetch. Per opcode:
  - 0 NOP: nothing.
  - 1 HLT: -> S_Halt.
  - 2 LDI: REG_WE=0, DATA_Src=00.
  - 3 LD: MEM_En=0, ADDR_Src=10; -> S_Exec.
  - 4 ST: MEM_Wr=0, MEM_En=0, ADDR_Src=10, Src1_Sel=0. Next state is S_Exec if WaitStates>0, else S_Fetch.
  - 5 STX: as ST but ADDR_Src=01, Src1_Sel=1.
  - 6 JPL/JMP: PC_Src=10, PC_Ld=0, STK_Ld=IR[11].
  - 7 RET: PC_Src=01, PC_Ld=0.
  - 8 BRD / 9 BRX: branch taken per CN (00 Z=1; 01 Z=0; 10 N!=V; 11 C=1). If taken: PC_Ld=0, PC_Src=00, BRA_Src=1 (BRD) or 0 (BRX). FLG_Rst=0 always.
  - A ADD=0000, B SUB=0001, C AND=0010, D OR=0011, E XOR=0100: ALU_Op register loaded, FLG_Ld=0, ALU_Ld=0; -> S_Exec.
  - F: Illegal=1, otherwise NOP.
- S_Exec: wait counter runs 0..WaitStates for LD/ST/STX and holds the Decode memory strobes throughout. At terminal count:
  - LD: REG_WE=0, DATA_Src=01.
  - ST/STX: release only.
  - ALU ops (no wait, single cycle): REG_WE=0, DATA_Src=10, ALU_Op held.
  - Then -> S_Fetch.
- S_Halt: Halt=1. Resume=1 -> S_Fetch next cycle; otherwise stay. InstrCnt frozen.
- Latency at WaitStates=W: NOP/LDI/JMP/BR = 3+W cycles; ALU = 4+W; LD = 4+2W.
- Reset asserted mid-access: state returns to S_Reset within the same cycle (async), wait counter clears, no write strobe survives.
- Resume while not in S_Halt: ignored.
- Unreachable state encodings: -> S_Reset.

Test Plan:
- Reset=0 for 3 cycles then 1, W=0, IR=16'h0000 -> PC_Rst=0 during reset; states Fetch, Load, Decode repeat every 3 cycles; InstrCnt=1,2,3.
- W=2, IR=16'h3005 (LD) -> MEM_En=0 for 3 cycles in Fetch; REG_WE=0 and DATA_Src=01 exactly one cycle, 8 cycles after Fetch entry.
- IR=16'h8xxx (BEQ): ALU_FlgsIn=4'b0001 -> PC_Ld=0, BRA_Src=1, FLG_Rst=0 in Decode; with 4'b0000 -> PC_Ld=1, FLG_Rst=0.
- IR=16'hA215 (ADD) -> Decode: ALU_Ld=0, FLG_Ld=0, ALU_Op=0000; Exec: REG_WE=0, DATA_Src=10, REG_Dest=1.
- IR=16'h1000 (HLT) -> Halt=1 held 10 cycles, InstrCnt unchanged; Resume=1 -> Fetch next cycle, Halt=0.
- IR=16'hF000 -> Illegal pulses 1 cycle; Reset dropped during a W=3 ST in S_Exec -> MEM_Wr=1 and MEM_En=1 in the same cycle.
